pdm_cic_decimator: RTL and testbench

Converts the 1-bit PDM microphone stream into signed 16-bit PCM samples using a 3-stage CIC (integrator–comb) decimator. Runs in the audio clock domain (clk_pdm, 4.8 MHz) directly upstream of the effects chain. Its `pcm_out` feeds the ring-modulator's `pcm_in`, and its `pcm_valid` marks each new sample for downstream sample-rate stages. With the default decimation of 100 it produces 48 kHz audio.

---
 rtl/pdm_cic_decimator.sv | 96 +++++++++
 tb/tb_pdm_cic_decimator.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : pdm_cic_decimator
// Description : 1-bit PDM to signed 16-bit PCM, 3-stage CIC decimate-by-DECIM.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_cic_decimator #(
    parameter int DECIM = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pdm_en,
    input  logic        pdm_in,
    output logic [15:0] pcm_out,
    output logic        pcm_valid
);

    localparam int ACC_W = 1 + 3 * $clog2(DECIM);
    localparam int CNT_W = $clog2(DECIM);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DECIM - 1);

    logic [ACC_W-1:0] r_i1, r_i2, r_i3;
    logic [ACC_W-1:0] r_cap, r_y1, r_y2;
    logic [ACC_W-1:0] r_d1, r_d2, r_d3;
    logic [CNT_W-1:0] r_cnt;
    logic             r_v0, r_v1, r_v2;

    logic [ACC_W-1:0] w_x;
    logic [ACC_W-1:0] w_i3_next;
    logic [ACC_W-1:0] w_y3;
    logic             w_strobe;
    logic [15:0]      w_pcm;

    assign w_x       = pdm_in ? ACC_W'(1) : {ACC_W{1'b1}};
    assign w_i3_next = r_i3 + r_i2;
    assign w_strobe  = pdm_en && (r_cnt == c_cnt_last);
    assign w_y3      = r_y2 - r_d3;

    // Small DECIM gives an accumulator narrower than the output; left-align it.
    generate
        if (ACC_W >= 16) begin : g_wide
            assign w_pcm = w_y3[ACC_W-1 -: 16];
        end else begin : g_narrow
            assign w_pcm = {w_y3, {(16 - ACC_W){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i1      <= '0;
            r_i2      <= '0;
            r_i3      <= '0;
            r_cnt     <= '0;
            r_cap     <= '0;
            r_y1      <= '0;
            r_y2      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            if (pdm_en) begin
                r_i1  <= r_i1 + w_x;
                r_i2  <= r_i2 + r_i1;
                r_i3  <= w_i3_next;
                r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
            end
            // Comb stages run every clock so gaps in pdm_en never stall a sample.
            r_v0 <= w_strobe;
            if (w_strobe) begin
                r_cap <= w_i3_next;
            end
            r_v1 <= r_v0;
            if (r_v0) begin
                r_y1 <= r_cap - r_d1;
                r_d1 <= r_cap;
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_y2 <= r_y1 - r_d2;
                r_d2 <= r_y1;
            end
            pcm_valid <= r_v2;
            if (r_v2) begin
                pcm_out <= w_pcm;
                r_d3    <= r_y2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pdm_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_cic_decimator
// Description : Scoreboard bench for pdm_cic_decimator with DECIM=100.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_cic_decimator;

    localparam int DECIM = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        pdm_en;
    logic        pdm_in;
    logic [15:0] pcm_out;
    logic        pcm_valid;

    pdm_cic_decimator #(.DECIM(DECIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .pdm_en    (pdm_en),
        .pdm_in    (pdm_in),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          edge_no;
        logic        chk;
        logic [15:0] val;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          bits   = 0;
    int          samp   = 0;
    logic [15:0] cur_val = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle; push the expected sample when this edge consumes the DECIM-th bit.
    task automatic step(input logic r, input logic e, input logic d, output logic e0);
        exp_t ent;
        @(negedge clk);
        rst = r; pdm_en = e; pdm_in = d; e0 = 1'b0;
        if (r) begin
            bits = 0; samp = 0;
            q.delete();
        end else if (e) begin
            bits++;
            if (bits % DECIM == 0) begin
                samp++;
                ent.edge_no = cyc + 4;
                ent.chk     = (samp >= 5);
                ent.val     = cur_val;
                q.push_back(ent);
                e0 = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        logic dummy;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'($urandom_range(0, 1)), dummy);
            @(posedge clk); #1;
            check("reset_pcm_out", int'(pcm_out), 0);
            check("reset_pcm_valid", int'(pcm_valid), 0);
        end
    endtask

    // pat: 0 = all ones, 1 = all zeros, 2 = alternating starting with 1
    task automatic run(input int pat, input int nsamp, input int period, input logic [15:0] val);
        logic e0;
        logic en, d;
        int   c;
        cur_val = val;
        do_reset();
        c = 0;
        while (samp < nsamp && c < nsamp * DECIM * period + 200) begin
            en = (c % period == 0);
            case (pat)
                0:       d = en;
                1:       d = 1'b0;
                default: d = (bits % 2 == 0);
            endcase
            step(1'b0, en, d, e0);
            c++;
        end
        if (samp < nsamp) check("run_timeout", samp, nsamp);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, e0);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (pcm_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_valid: pcm_valid=1 pcm_out=%0d with no sample expected (cycle %0d)",
                             $signed(pcm_out), cyc);
                end else begin
                    e = q.pop_front();
                    check("valid_timing", cyc, e.edge_no);
                    if (e.chk) check("pcm_value", int'($signed(pcm_out)), int'($signed(e.val)));
                end
            end else if (pcm_valid !== 1'b0) begin
                checks++; errors++;
                $display("FAIL valid_unknown: pcm_valid=%b required 0 or 1 (cycle %0d)", pcm_valid, cyc);
            end
        end
    end

    initial begin : stim
        logic e0;
        int   c;
        rst = 1'b1; pdm_en = 1'b0; pdm_in = 1'b0;

        run(0, 10, 1, 16'h3D09);
        run(1, 10, 1, 16'hC2F7);
        run(2, 10, 1, 16'h0000);
        run(0, 8,  3, 16'h3D09);

        // Reset one cycle after E0 discards that sample; then a long all-ones run.
        cur_val = 16'h3D09;
        do_reset();
        e0 = 1'b0;
        c  = 0;
        while (!(e0 && samp == 3) && c < 400) begin
            step(1'b0, 1'b1, 1'b1, e0);
            c++;
        end
        check("midreset_reached_e0", samp, 3);
        step(1'b1, 1'b1, 1'b1, e0);
        step(1'b1, 1'b1, 1'b0, e0);
        c = 0;
        while (samp < 60 && c < 60 * DECIM + 200) begin
            step(1'b0, 1'b1, 1'b1, e0);
            c++;
        end
        if (samp < 60) check("long_run_timeout", samp, 60);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, e0);
        check("queue_drained_final", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
